// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: combinational per-stage hold vector, registered
// flush pulse with redirect PC, stall watchdog and stall-cycle performance counter.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 64,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    input  logic        clear_timeout,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic              flush_q;
    logic [31:0]       new_pc_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              timeout_q;
    logic [31:0]       stall_cycles_q;
    logic              any_req_s;
    logic              stall_active_s;

    assign any_req_s      = stallreq_id | stallreq_ex | stallreq_mem;
    assign stall_active_s = (stall != 6'b000000);

    // FSM state register and flush countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // FSM next-state logic; a flush request restarts FLUSH from any state
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (flush_req) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                ST_RUN:   state_d = any_req_s ? ST_STALL : ST_RUN;
                ST_STALL: state_d = any_req_s ? ST_STALL : ST_RUN;
                ST_FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                    end
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM output: zero-latency hold vector, suppressed in reset and while flushing
    always_comb begin
        stall = 6'b000000;
        if (rst) begin
            stall = 6'b000000;
        end else if (state_q == ST_FLUSH) begin
            stall = 6'b000000;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (stallreq_ex) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else begin
            stall = 6'b000000;
        end
    end

    // Flush pulse mirrors the next FLUSH state; redirect PC captured with the request
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
        end else begin
            flush_q  <= (state_d == ST_FLUSH);
            new_pc_q <= flush_req ? flush_pc : new_pc_q;
        end
    end

    // Watchdog: saturating run-length of consecutive stalls, sticky timeout (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (stall_active_s) begin
                stall_cnt_q <= (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                               : stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= '0;
            end
            if (stall_active_s && (stall_cnt_q == CNT_W'(MAX_STALL - 1))) begin
                timeout_q <= 1'b1;
            end else if (clear_timeout) begin
                timeout_q <= 1'b0;
            end else begin
                timeout_q <= timeout_q;
            end
        end
    end

    // Performance counter of stalled cycles, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else if (stall_active_s) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_q <= stall_cycles_q;
        end
    end

    assign flush         = flush_q;
    assign new_pc        = new_pc_q;
    assign stall_timeout = timeout_q;
    assign stall_cycles  = stall_cycles_q;

endmodule
